seq_mult_w: RTL and testbench

- Parametrised sequential shift-and-add multiplier; successor to the fixed 4-bit combinational array multiplier.
- Trades area for latency: one partial-product accumulation per clock.
- Adds a start/busy/done handshake and a per-operation signed or unsigned mode.
- Sits as a shared arithmetic unit behind a controller that issues one operation at a time.

---
 rtl/seq_mult_pkg.sv | 11 +
 rtl/mult_abs.sv | 10 +
 rtl/seq_mult_w.sv | 67 ++++++
 tb/tb_seq_mult_w.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: state type and encodings shared by the sequential multiplier
package seq_mult_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;
    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CALC   = ST_CALC,
        FINISH = ST_FINISH
    } mult_state_t;
endpackage

// File: rtl/mult_abs.sv
// mult_abs: operand magnitude; passes x through unchanged in unsigned mode
module mult_abs #(
    parameter int WIDTH = 8
) (
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] mag
);
    assign mag = (signed_mode && x[WIDTH-1]) ? -x : x;
endmodule

// File: rtl/seq_mult_w.sv
// seq_mult_w: shift-and-add multiplier, one partial product per clock, signed or unsigned
module seq_mult_w
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    mult_state_t state, state_n;
    logic [WIDTH-1:0] mag_a, mag_b, abs_a, abs_b;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0] sum;
    logic [CNT_W-1:0] cnt;
    logic neg;

    mult_abs #(.WIDTH(WIDTH)) u_abs_a (.signed_mode(signed_mode), .x(a), .mag(abs_a));
    mult_abs #(.WIDTH(WIDTH)) u_abs_b (.signed_mode(signed_mode), .x(b), .mag(abs_b));

    assign busy = state != IDLE;
    // extra top bit keeps the carry, which shifts back into the upper half
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a & {WIDTH{mag_b[0]}}};

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? CALC : IDLE) :
                  state == CALC ? (cnt == CNT_W'(1) ? FINISH : CALC) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            product <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            state <= state_n;
            done  <= state == FINISH;
            if (state == IDLE && start) begin
                mag_a <= abs_a;
                mag_b <= abs_b;
                neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc   <= '0;
                cnt   <= CNT_W'(WIDTH);
            end
            if (state == CALC) begin
                acc   <= {sum, acc[WIDTH-1:1]};
                mag_b <= mag_b >> 1;
                cnt   <= cnt - 1'b1;
            end
            if (state == FINISH)
                product <= neg ? -acc : acc;
        end
    end
endmodule

// File: tb/tb_seq_mult_w.sv
// tb_seq_mult_w: random and corner-case checks of seq_mult_w at WIDTH=8 and WIDTH=4
module tb_seq_mult_w;
    logic clk = 0, rst_n = 0;
    logic s8 = 0, sm8 = 0, s4 = 0, sm4 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic busy8, done8, busy4, done4;
    logic [15:0] prod8;
    logic [7:0] prod4;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    seq_mult_w #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .start(s8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8));
    seq_mult_w #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .start(s4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4));

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint ref_mul(input int w, input bit sm, input longint x, input longint y);
        longint m = (longint'(1) << (2 * w)) - 1;
        if (sm && x[w-1]) x -= longint'(1) << w;
        if (sm && y[w-1]) y -= longint'(1) << w;
        return (x * y) & m;
    endfunction

    task automatic op8(input bit sm, input logic [7:0] x, input logic [7:0] y,
                       output int lat, output int bcnt, output logic [15:0] p);
        @(negedge clk); s8 = 1; sm8 = sm; a8 = x; b8 = y;
        @(posedge clk); #1 s8 = 0;
        lat = 0; bcnt = int'(busy8);
        while (!done8 && lat < 50) begin
            @(posedge clk); #1 lat++;
            bcnt += int'(busy8);
        end
        p = prod8;
    endtask

    task automatic op4(input bit sm, input logic [3:0] x, input logic [3:0] y,
                       output int lat, output logic [7:0] p);
        @(negedge clk); s4 = 1; sm4 = sm; a4 = x; b4 = y;
        @(posedge clk); #1 s4 = 0;
        lat = 0;
        while (!done4 && lat < 50) begin
            @(posedge clk); #1 lat++;
        end
        p = prod4;
    endtask

    initial begin
        int lat, bc, lat_bad, hits;
        logic [15:0] p, p0;
        logic [7:0] q;
        logic [7:0] ra, rb;
        bit rs;
        #22;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_prod", prod8, 0);
        check("rst_prod4", prod4, 0);
        @(negedge clk); rst_n = 1;

        op8(0, 8'd255, 8'd255, lat, bc, p);
        check("u255_prod", p, 16'hFE01);
        check("u255_lat", lat, 9);
        check("u255_busy", bc, 9);

        op8(1, 8'h80, 8'h80, lat, bc, p); check("s_m128_m128", p, 16'h4000);
        op8(1, 8'h80, 8'h7F, lat, bc, p); check("s_m128_127", p, 16'hC080);
        op8(1, 8'hFF, 8'h01, lat, bc, p); check("s_m1_1", p, 16'hFFFF);
        op8(1, 8'h00, 8'hFB, lat, bc, p); check("s_0_m5", p, 16'h0000);
        check("s_lat", lat, 9);

        // start pulsed while busy must be dropped, not queued
        @(negedge clk); s8 = 1; sm8 = 0; a8 = 8'd3; b8 = 8'd5;
        @(posedge clk); #1 s8 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); s8 = 1; a8 = 8'd2; b8 = 8'd2;
        @(negedge clk); s8 = 0;
        lat = 0;
        while (!done8 && lat < 50) begin @(posedge clk); #1 lat++; end
        check("busy_ign_prod", prod8, 15);
        hits = 0;
        repeat (14) begin @(posedge clk); #1 hits += int'(done8); end
        check("busy_ign_noq", hits, 0);

        // back-to-back: second start issued during the done cycle
        op8(0, 8'd7, 8'd9, lat, bc, p);
        check("b2b_first", p, 63);
        check("b2b_done_now", done8, 1);
        op8(1, 8'hF6, 8'd12, lat, bc, p);
        check("b2b_lat", lat, 9);
        check("b2b_prod", p, ref_mul(8, 1, 64'hF6, 12));

        repeat (40) begin
            rs = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            op8(rs, ra, rb, lat, bc, p);
            check($sformatf("rnd8 %0d*%0d sm%0d", ra, rb, rs), p, ref_mul(8, rs, ra, rb));
        end

        // hold: product stays, no done while inputs wander
        p0 = prod8; hits = 0;
        repeat (20) begin
            @(negedge clk); a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm8;
            @(posedge clk); #1 hits += int'(done8 || prod8 != p0);
        end
        check("hold", hits, 0);

        lat_bad = 0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 256; i++) begin
                op4(m[0], 4'(i >> 4), 4'(i), lat, q);
                lat_bad += int'(lat != 5);
                check($sformatf("w4 sm%0d %0d*%0d", m, i >> 4, i & 15), q,
                      ref_mul(4, m[0], longint'(i >> 4), longint'(i & 15)));
            end
        check("w4_lat", lat_bad, 0);

        // async reset in the middle of 13*11
        @(negedge clk); s8 = 1; sm8 = 0; a8 = 8'd13; b8 = 8'd11;
        @(posedge clk); #1 s8 = 0;
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_prod", prod8, 0);
        @(negedge clk); rst_n = 1;
        hits = 0;
        repeat (15) begin @(posedge clk); #1 hits += int'(done8); end
        check("mid_rst_nodone", hits, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
